// File: rtl/pwm_peak_current_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_peak_current_ctrl
//
// Peak-current-mode PWM generator for the buck output stage (48 MHz clk_i).
// Each switching period starts with pwm_o high. The pulse ends when the
// estimated coil current reaches the setpoint, after at least MIN_ON cycles
// of blanking. MAX_ON caps the pulse length. A measured output current above
// OC_LIMIT latches a fault that holds pwm_o low until fault_clear_i.
//
// State table:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | enable low; cnt held at PERIOD-1, pwm low
//   S_ON    | switch on; on_cnt_q counts high cycles
//   S_OFF   | switch off until the next period start
//   S_FAULT | over-current latched; pwm low, counter keeps running
//
// Ports:
//   clk_i          in   1  system clock (48 MHz)
//   reset_i        in   1  asynchronous, active-high reset
//   enable_i       in   1  run request, level sensitive
//   ipeak_set_i    in  11  peak current setpoint, unsigned DN; 0 = no pulses
//   iest_coil_i    in  12  estimated coil current, ADC native format
//   iout_i         in  12  measured output current, ADC native format
//   iout_valid_i   in   1  one-cycle strobe for a new iout_i sample
//   fault_clear_i  in   1  one-cycle pulse, clears a latched fault
//   pwm_o          out  1  switch drive (registered)
//   period_start_o out  1  high in the first cycle of each period (registered)
//   fault_o        out  1  latched over-current flag (registered)
//   on_time_o      out  8  width of the last completed pulse, in cycles
// -----------------------------------------------------------------------------
module pwm_peak_current_ctrl #(
  parameter int unsigned PERIOD   = 96,
  parameter int unsigned MIN_ON   = 4,
  parameter int unsigned MAX_ON   = 80,
  parameter int unsigned OC_LIMIT = 1845
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [10:0] ipeak_set_i,
  input  logic [11:0] iest_coil_i,
  input  logic [11:0] iout_i,
  input  logic        iout_valid_i,
  input  logic        fault_clear_i,
  output logic        pwm_o,
  output logic        period_start_o,
  output logic        fault_o,
  output logic [7:0]  on_time_o
);

  localparam logic [7:0]  CNT_LAST = 8'(PERIOD - 1);
  localparam logic [7:0]  MIN_ON_C = 8'(MIN_ON);
  localparam logic [7:0]  MAX_ON_C = 8'(MAX_ON);
  localparam logic [10:0] OC_LIM_C = 11'(OC_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_OFF   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // ADC native code: bit 11 set means negative current (clamped to 0 A);
  // otherwise the lower 11 bits are inverted, so 0x7FF is 0 A.
  function automatic logic [10:0] adc_mag(input logic [11:0] code);
    return code[11] ? 11'd0 : (code[10:0] ^ 11'h7FF);
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  on_cnt_q, on_cnt_d;
  logic [7:0]  on_time_q, on_time_d;
  logic        pwm_q, pwm_d;
  logic        ps_q, ps_d;
  logic        fault_q, fault_d;

  logic [10:0] iest_mag;
  logic [10:0] iout_mag;
  logic        wrap;
  logic        oc_trip;
  logic        pk_hit;
  logic        terminate;

  assign iest_mag  = adc_mag(iest_coil_i);
  assign iout_mag  = adc_mag(iout_i);
  assign wrap      = enable_i && (cnt_q == CNT_LAST);
  assign oc_trip   = enable_i && iout_valid_i && (iout_mag > OC_LIM_C);
  assign pk_hit    = (iest_mag >= ipeak_set_i);
  assign terminate = ((on_cnt_q >= MIN_ON_C) && pk_hit) || (on_cnt_q == MAX_ON_C);

  always_comb begin
    cnt_d     = enable_i ? ((cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1) : CNT_LAST;
    ps_d      = wrap;
    state_d   = state_q;
    pwm_d     = pwm_q;
    fault_d   = fault_q;
    on_time_d = on_time_q;
    on_cnt_d  = on_cnt_q;

    if (!enable_i) begin
      // Disable aborts any pulse at once; a latched fault survives.
      state_d = S_IDLE;
      pwm_d   = 1'b0;
    end else if (oc_trip) begin
      // Over-current beats MIN_ON and a coincident fault_clear_i.
      state_d = S_FAULT;
      pwm_d   = 1'b0;
      fault_d = 1'b1;
    end else if (state_q == S_FAULT) begin
      if (fault_clear_i) begin
        state_d = S_OFF;
        fault_d = 1'b0;
      end
    end else if (wrap) begin
      if (!fault_q && (ipeak_set_i != 11'd0)) begin
        state_d  = S_ON;
        pwm_d    = 1'b1;
        on_cnt_d = 8'd1;
      end else if (fault_q) begin
        state_d = S_FAULT;
        pwm_d   = 1'b0;
      end else begin
        state_d = S_OFF;
        pwm_d   = 1'b0;
      end
    end else if (state_q == S_ON) begin
      if (terminate) begin
        state_d   = S_OFF;
        pwm_d     = 1'b0;
        on_time_d = on_cnt_q;
      end else begin
        on_cnt_d = on_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_LAST;
      on_cnt_q  <= 8'd0;
      on_time_q <= 8'd0;
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      on_cnt_q  <= on_cnt_d;
      on_time_q <= on_time_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
      fault_q   <= fault_d;
    end
  end

  assign pwm_o          = pwm_q;
  assign period_start_o = ps_q;
  assign fault_o        = fault_q;
  assign on_time_o      = on_time_q;

endmodule

// File: tb/tb_pwm_peak_current_ctrl.sv
// Random-period scoreboard bench for pwm_peak_current_ctrl, followed by
// directed enable, fault and asynchronous reset sequences.
module tb_pwm_peak_current_ctrl;

  localparam int PERIOD   = 96;
  localparam int MIN_ON   = 4;
  localparam int MAX_ON   = 80;
  localparam int OC_LIMIT = 1845;
  localparam int NP       = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] ipeak_set = 11'd0;
  logic [11:0] iest_coil = 12'h7FF;
  logic [11:0] iout = 12'h7FF;
  logic        iout_valid = 1'b0;
  logic        fault_clear = 1'b0;
  logic        pwm;
  logic        period_start;
  logic        fault;
  logic [7:0]  on_time;

  pwm_peak_current_ctrl #(
    .PERIOD(PERIOD), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .OC_LIMIT(OC_LIMIT)
  ) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .ipeak_set_i(ipeak_set),
    .iest_coil_i(iest_coil), .iout_i(iout), .iout_valid_i(iout_valid),
    .fault_clear_i(fault_clear), .pwm_o(pwm), .period_start_o(period_start),
    .fault_o(fault), .on_time_o(on_time)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Current magnitude (0..2047) to ADC native code.
  function automatic logic [11:0] m2c(int m);
    logic [10:0] mm;
    mm = 11'(m);
    return {1'b0, mm ^ 11'h7FF};
  endfunction

  typedef struct {
    int width;
    int on_time;
    int fault;
  } exp_t;
  exp_t sb[$];
  bit   mon_en = 1'b0;

  // Per-period scenario. trip: high cycle (1-based) from which the coil
  // current is at/above setpoint, 0 = never. oc/clr: period cycle index
  // (cnt value) of the over-current strobe / fault_clear pulse, 0 = none.
  int ipk [NP+1];
  int trip[NP+1];
  int oc  [NP+1];
  int clr [NP+1];
  int hmag[NP+1];

  // Monitor: closes a period at every period_start and checks it.
  int   mon_hi = 0, mon_len = 0, last_ot = 0, last_fault = 0;
  bit   mon_started = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_started = 1'b0;
    end else begin
      if (period_start) begin
        if (mon_started) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            mon_e = sb.pop_front();
            chk("pulse_width", mon_hi, mon_e.width);
            chk("on_time", last_ot, mon_e.on_time);
            chk("fault_end", last_fault, mon_e.fault);
            chk("period_len", mon_len, PERIOD);
          end
        end
        mon_started = 1'b1;
        mon_hi      = 0;
        mon_len     = 0;
      end
      if (mon_started) begin
        mon_len++;
        if (pwm) mon_hi++;
      end
    end
    last_ot    = int'(on_time);
    last_fault = int'(fault);
  end

  int mf  = 0;   // model fault flag
  int mot = 0;   // model on_time

  initial begin
    int w;
    int mag;
    exp_t e;

    // Scenario table: directed periods first, then random.
    for (int p = 0; p <= NP; p++) begin
      hmag[p] = -1;
      if ($urandom_range(0, 9) == 0) ipk[p] = 0;
      else ipk[p] = $urandom_range(2047, 1);
      trip[p] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(90, 1);
      oc[p]   = ($urandom_range(0, 7) == 0) ? $urandom_range(90, 1) : 0;
      if ($urandom_range(0, 4) == 0) clr[p] = $urandom_range(90, 1);
      else if (oc[p] != 0 && $urandom_range(0, 3) == 0) clr[p] = oc[p];
      else clr[p] = 0;
    end
    for (int p = 0; p < 12; p++) begin
      ipk[p] = 410; trip[p] = 0; oc[p] = 0; clr[p] = 0;
    end
    trip[1] = 20; hmag[1] = 410;     // exactly at setpoint
    trip[2] = 1;  hmag[2] = 1023;    // min on-time
    oc[3]   = 1;                     // second high cycle
    clr[6]  = 48;
    trip[7] = 30;
    oc[8]   = 1;  clr[8] = 1;        // clear loses to coincident over-current
    clr[9]  = 30;
    ipk[10] = 0;
    trip[11] = 2;
    ipk[NP] = 0; trip[NP] = 0; oc[NP] = 0; clr[NP] = 10;

    // Reset
    #2 reset = 1'b1;
    #1;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_on_time", int'(on_time), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_pwm", int'(pwm), 0);
    chk("idle_ps", int'(period_start), 0);

    // Random scoreboard phase
    ipeak_set = 11'(ipk[0]);
    enable    = 1'b1;
    mon_en    = 1'b1;
    for (int p = 0; p <= NP; p++) begin
      if (mf != 0 || ipk[p] == 0) begin
        w = 0;
      end else begin
        w = (trip[p] == 0) ? MAX_ON : trip[p];
        if (w < MIN_ON) w = MIN_ON;
        if (w > MAX_ON) w = MAX_ON;
        if (oc[p] != 0 && oc[p] + 1 <= w) w = oc[p] + 1;
        else mot = w;
      end
      for (int i = 1; i <= 90; i++) begin
        if (oc[p] == i) mf = 1;
        else if (clr[p] == i) mf = 0;
      end
      if (p < NP) begin
        e.width = w; e.on_time = mot; e.fault = mf;
        sb.push_back(e);
      end

      for (int i = 0; i < PERIOD; i++) begin
        @(negedge clk);
        if (ipk[p] != 0 && trip[p] != 0 && i >= trip[p] - 1) begin
          mag = (hmag[p] >= 0) ? hmag[p] : int'($urandom_range(2047, ipk[p]));
          iest_coil = m2c(mag);
        end else if (p < 12) begin
          iest_coil = 12'h7FF;
        end else if (ipk[p] == 0) begin
          iest_coil = 12'($urandom);
        end else if ($urandom_range(0, 3) == 0) begin
          iest_coil = 12'h800 | 12'($urandom_range(2047, 0));
        end else begin
          iest_coil = m2c($urandom_range(ipk[p] - 1, 0));
        end

        if (oc[p] != 0 && i == oc[p]) begin
          iout_valid = 1'b1;
          iout = (p < 12) ? m2c(OC_LIMIT + 1) : m2c($urandom_range(2047, OC_LIMIT + 1));
        end else if (i % 16 == 7) begin
          iout_valid = 1'b1;
          case ($urandom_range(0, 3))
            0:       iout = m2c(OC_LIMIT);
            1:       iout = 12'h800 | 12'($urandom_range(2047, 0));
            default: iout = m2c($urandom_range(OC_LIMIT, 0));
          endcase
        end else begin
          iout_valid = 1'b0;
          iout = 12'($urandom);
        end

        fault_clear = (clr[p] != 0 && i == clr[p]);

        if (i == PERIOD - 1) begin
          if (p < NP) begin
            ipeak_set = 11'(ipk[p+1]);
          end else begin
            enable = 1'b0;
            mon_en = 1'b0;
          end
        end
      end
    end
    chk("sb_empty", sb.size(), 0);

    // Enable gating
    iout_valid  = 1'b0;
    iout        = 12'h7FF;
    fault_clear = 1'b0;
    iest_coil   = 12'h7FF;
    repeat (3) @(negedge clk);
    chk("dis_pwm", int'(pwm), 0);
    chk("dis_ps", int'(period_start), 0);
    ipeak_set = 11'd410;
    enable    = 1'b1;
    @(negedge clk);
    chk("reen_pwm", int'(pwm), 1);
    chk("reen_ps", int'(period_start), 1);
    repeat (9) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_pwm", int'(pwm), 0);
    chk("drop_fault", int'(fault), 0);

    // Over-current, then disable: fault must survive
    enable = 1'b1;
    @(negedge clk);
    chk("oc_start_pwm", int'(pwm), 1);
    @(negedge clk);
    iout_valid = 1'b1;
    iout       = 12'h0C9;
    @(negedge clk);
    iout_valid = 1'b0;
    iout       = 12'h7FF;
    chk("oc_pwm", int'(pwm), 0);
    chk("oc_fault", int'(fault), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_keep_fault", int'(fault), 1);
    chk("dis_keep_pwm", int'(pwm), 0);

    // Re-enable while faulted, clear mid-period, pulse at next wrap
    enable = 1'b1;
    @(negedge clk);
    chk("flt_wrap_pwm", int'(pwm), 0);
    chk("flt_wrap_ps", int'(period_start), 1);
    repeat (2) @(negedge clk);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    chk("clr_fault", int'(fault), 0);
    chk("clr_pwm", int'(pwm), 0);
    repeat (PERIOD - 4) @(negedge clk);
    chk("clr_wait_pwm", int'(pwm), 0);
    @(negedge clk);
    chk("resume_pwm", int'(pwm), 1);
    chk("resume_ps", int'(period_start), 1);

    // Asynchronous reset mid-pulse, between edges
    repeat (4) @(negedge clk);
    chk("pre_reset_pwm", int'(pwm), 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_pwm", int'(pwm), 0);
    chk("arst_fault", int'(fault), 0);
    chk("arst_on_time", int'(on_time), 0);
    chk("arst_ps", int'(period_start), 0);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_peak_current_ctrl.md
Name: pwm_peak_current_ctrl

Overview:
- Peak-current-mode PWM generator for the buck output stage. Runs on the 48 MHz system clock.
- Drives `pwm` into the coil current model.
- Consumes the model's coil current estimate to end each on-time.
- Uses the measured ADC output current for latched over-current protection.

Parameters:
- PERIOD, 96, switching period in clk cycles (500 kHz at 48 MHz); range 8..255
- MIN_ON, 4, minimum on-time in cycles (leading-edge blanking); range 1..MAX_ON
- MAX_ON, 80, maximum on-time in cycles; must be <= PERIOD-1
- OC_LIMIT, 1845, over-current threshold in current DN (205 DN/A, so 9 A)

Ports:
- clk  in  1  48 MHz system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request; level sensitive
- ipeak_set  in  11  peak current setpoint, unsigned DN (205 DN/A); 0 = no pulses
- iest_coil  in  12  estimated coil current, ADC native format
- iout  in  12  measured output current, ADC native format
- iout_valid  in  1  one-cycle strobe marking a new iout sample (3 MHz)
- fault_clear  in  1  one-cycle pulse; clears a latched fault
- pwm  out  1  switch drive; registered
- period_start  out  1  high for the first cycle of each period; registered
- fault  out  1  latched over-current flag; registered
- on_time  out  8  on-time of the last completed pulse, in cycles; registered

Behaviour:
- Reset: asynchronous, active-high.
  - Clears pwm, period_start, fault and on_time to 0.
  - Sets cnt to PERIOD-1 and the state to IDLE.
- ADC-native to magnitude conversion, applied to both iest_coil and iout:
  - mag = code[11] ? 0 : (code ^ 12'h7FF)
  - Result is 11-bit unsigned; code 0x7FF means 0 A.
- Period counter cnt (8 bits):
  - Held at PERIOD-1 while enable=0.
  - Otherwise increments each clk and wraps from PERIOD-1 to 0.
  - period_start = 1 exactly in cycles where cnt==0 and enable=1.
- States: IDLE, ON, OFF, FAULT.
- IDLE:
  - pwm=0.
  - If enable=1, go to ON when cnt wraps to 0; otherwise stay.
  - The first enabled edge wraps cnt, so pwm rises 1 cycle after enable is sampled high.
- Period start (the edge where cnt goes from PERIOD-1 to 0):
  - If enable=1, fault=0 and ipeak_set!=0: set pwm=1, set on_cnt=1, enter ON.
  - Otherwise pwm stays 0 and the state becomes OFF (or stays FAULT).
- ON:
  - on_cnt increments each cycle; it is 1 in the first high cycle.
  - Terminate when (on_cnt >= MIN_ON and mag(iest_coil) >= ipeak_set) or on_cnt == MAX_ON.
  - On terminate, the next edge sets pwm=0, latches on_time=on_cnt and enters OFF.
  - Resulting pulse width is always MIN_ON..MAX_ON cycles.
  - Because MAX_ON < PERIOD, every pulse is followed by at least one low cycle, so every period produces a fresh rising edge.
- OFF: pwm=0 until the next period start.
- Over-current:
  - Trigger: iout_valid=1 and mag(iout) > OC_LIMIT, in any state with enable=1.
  - Effect on the next edge: fault=1, pwm=0, enter FAULT. This overrides MIN_ON.
  - on_time is not updated by a fault-terminated pulse.
- FAULT:
  - pwm held at 0 and cnt keeps running.
  - fault_clear=1 sets fault=0 and goes to OFF; pulses resume at the next period start.
  - If fault_clear and a new over-current arrive in the same cycle, the fault wins: fault stays 1.
- enable falling:
  - Next edge sets pwm=0, cnt=PERIOD-1 and state IDLE, regardless of MIN_ON.
  - fault is preserved.
- Asynchronous reset mid-pulse: pwm drops immediately without waiting for a clk edge. on_time returns to 0.
- ipeak_set change mid-pulse: the new value takes effect on the next comparison cycle; nothing is latched per period.
- All outputs are direct register outputs; there is no combinational path from any input to any output.

Test Plan:
- Max on-time clamp:
  - Stimulus: enable=1, ipeak_set=410, iest_coil held at 0x7FF (0 A).
  - Required: pwm high 80 cycles, low 16, repeating every 96; on_time=80; period_start pulses every 96 cycles.
- Peak current termination:
  - Stimulus: as above, but iest_coil steps to 0x665 (mag 410) in the 20th high cycle.
  - Required: pwm falls on the following edge; 20 cycles high; on_time=20.
- Minimum on-time:
  - Stimulus: iest_coil held at 0x400 (mag 1023) with ipeak_set=410.
  - Required: every pulse is exactly 4 cycles; on_time=4.
- Over-current latch:
  - Stimulus: iout=0x0C9 (mag 1846) with iout_valid in the 2nd high cycle.
  - Required: pwm=0 next edge; fault=1; no pulses for 3 periods.
  - Then pulse fault_clear mid-period. Required: fault=0; pwm rises at the next cnt wrap.
  - Repeat with fault_clear coincident with the over-current strobe. Required: fault stays 1.
- Enable and setpoint gating:
  - Stimulus: drop enable in the 10th high cycle.
  - Required: pwm=0 next edge. After re-enable, pwm rises 1 cycle later.
  - Stimulus: ipeak_set=0. Required: no pwm pulses while period_start keeps pulsing.
- Async reset:
  - Stimulus: assert reset between clk edges during a pulse.
  - Required: pwm=0, fault=0, on_time=0 immediately, before the next edge.
